// File: rtl/count_ctrl_pkg.sv
// Shared types for the counting-run controller: FSM states and the run command record.
package count_ctrl_pkg;

    localparam int W_COE = 8;
    localparam int CMD_W = 3 * W_COE;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef struct packed {
        logic [W_COE-1:0] start;
        logic [W_COE-1:0] step;
        logic [W_COE-1:0] len;
    } cmd_t;

endpackage

// File: rtl/count_run_ctrl_if.sv
// Command port of the counting-run controller.
// Handshake: a command transfers on a rising clock edge where cmd_valid && cmd_ready;
// cmd_start/cmd_step/cmd_len are sampled on that edge. cmd_ready may drop without a
// transfer (FIFO full or abort) and the host keeps cmd_valid and the fields until it transfers.
interface count_run_ctrl_if;
    import count_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [W_COE-1:0] cmd_start;
    logic [W_COE-1:0] cmd_step;
    logic [W_COE-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_start, output cmd_step, output cmd_len,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_start, input  cmd_step, input  cmd_len,
                    output cmd_ready);
endinterface

// File: rtl/count_cmd_fifo.sv
// Synchronous show-ahead command FIFO with flush; full/empty from wrap-bit pointers.
module count_cmd_fifo
    import count_ctrl_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic clock,
    input  logic rstn,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  cmd_t wdata,
    output cmd_t rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    cmd_t        mem_q [QDEPTH];
    cmd_t        mem_d [QDEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers and storage; flush drops everything and ignores push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Pointer registers reset; storage contents need no reset.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/count_run_ctrl.sv
// Counting-run sequencer: pops queued commands, loads start, adds step len times, pulses done.
module count_run_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                 clock,
    input  logic                 rstn,
    count_run_ctrl_if.slave      cmd_if,
    input  logic                 hold,
    input  logic                 abort,
    output logic [W_COE-1:0]     count,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap,
    output state_e               state_o
);
    localparam logic [W_COE-1:0] ONE_W = 1;

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [W_COE-1:0] count_q, count_d;
    logic [W_COE-1:0] remaining_q, remaining_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    cmd_t             fifo_wdata, fifo_rdata;
    logic [W_COE:0]   sum;

    assign cmd_if.cmd_ready = !fifo_full && !abort;
    assign fifo_push        = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign fifo_pop         = (state_q == IDLE) && !fifo_empty && !abort;
    assign fifo_wdata       = '{start: cmd_if.cmd_start, step: cmd_if.cmd_step, len: cmd_if.cmd_len};
    assign sum              = {1'b0, count_q} + {1'b0, cmd_q.step};

    count_cmd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clock (clock),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (abort),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and datapath. HOLD behaves like RUN with the add gated, so the edge that
    // sees hold drop already performs the next add: a hold of N cycles delays done by N.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        wrap_d      = wrap_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_d   = fifo_rdata;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    count_d     = cmd_q.start;
                    remaining_d = cmd_q.len;
                    wrap_d      = 1'b0;
                    state_d     = (cmd_q.len == '0) ? DONE : RUN;
                end
                RUN, HOLD: begin
                    if (hold) begin
                        state_d = HOLD;
                    end else begin
                        count_d     = sum[W_COE-1:0];
                        wrap_d      = wrap_q | sum[W_COE];
                        remaining_d = remaining_q - ONE_W;
                        state_d     = (remaining_q == ONE_W) ? DONE : RUN;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Bench for count_run_ctrl: run-level reference model plus directed literal checks.
module tb_count_run_ctrl;
    import count_ctrl_pkg::*;

    localparam int QDEPTH = 2;
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rstn  = 1'b0;
    logic hold  = 1'b0;
    logic abort = 1'b0;
    logic [7:0] count;
    logic busy, done, wrap;
    state_e state_dbg;

    always #5 clock = ~clock;

    count_run_ctrl_if bus();

    count_run_ctrl #(.QDEPTH(QDEPTH)) dut (
        .clock   (clock),
        .rstn    (rstn),
        .cmd_if  (bus),
        .hold    (hold),
        .abort   (abort),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap),
        .state_o (state_dbg)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Count and wrap come from the closed form start + k*step over k completed adds.
    logic [23:0] mq[$];
    int   mph = P_IDLE;
    int   mk = 0, cur_s = 0, cur_t = 0, cur_l = 0;
    int   mc = 0;
    bit   mw = 0, mdone = 0, mbusy = 0, do_push = 0;
    logic [23:0] popped;

    always @(posedge clock) begin
        if (!rstn) begin
            mq.delete();
            mph = P_IDLE; mk = 0; mc = 0; mw = 0;
        end else if (abort) begin
            mq.delete();
            mph = P_IDLE;
        end else begin
            do_push = bus.cmd_valid && (mq.size() < QDEPTH);
            case (mph)
                P_IDLE: if (mq.size() > 0) begin
                    popped = mq.pop_front();
                    cur_s = int'(popped[23:16]); cur_t = int'(popped[15:8]); cur_l = int'(popped[7:0]);
                    mph = P_LOAD;
                end
                P_LOAD: begin
                    mk = 0; mc = cur_s; mw = 0;
                    mph = (cur_l == 0) ? P_DONE : P_RUN;
                end
                P_RUN: if (!hold) begin
                    mk++;
                    mc = (cur_s + mk * cur_t) % 256;
                    mw = (cur_s + mk * cur_t) > 255;
                    if (mk == cur_l) mph = P_DONE;
                end
                default: mph = P_IDLE;
            endcase
            if (do_push) mq.push_back({bus.cmd_start, bus.cmd_step, bus.cmd_len});
        end
        mdone = (mph == P_DONE);
        mbusy = (mph != P_IDLE);
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    logic [7:0] exp_q[$];
    logic [7:0] done_log[$];

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("m_count", 32'(count), 32'(mc));
            chk("m_busy",  32'(busy),  32'(mbusy));
            chk("m_done",  32'(done),  32'(mdone));
            chk("m_wrap",  32'(wrap),  32'(mw));
            chk("m_ready", 32'(bus.cmd_ready), 32'((mq.size() < QDEPTH) && !abort));
            if (done) done_log.push_back(count);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic send(input logic [7:0] s, input logic [7:0] st, input logic [7:0] l);
        bus.cmd_valid = 1'b1; bus.cmd_start = s; bus.cmd_step = st; bus.cmd_len = l;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (bus.cmd_ready) begin
                @(posedge clock); #1;
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        vectors++; miscompares++;
        $display("FAIL send_timeout actual=not_accepted required=accepted");
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            if (mph == P_IDLE && mq.size() == 0 && !busy) return;
            tick();
        end
        vectors++; miscompares++;
        $display("FAIL idle_timeout actual=busy required=idle");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_start = '0; bus.cmd_step = '0; bus.cmd_len = '0;
        repeat (3) tick();
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_done",  32'(done),  32'h0);
        chk("rst_wrap",  32'(wrap),  32'h0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        cmp_en = 1'b1;
        rstn = 1'b1;
        tick();

        // Basic run
        send(8'h0F, 8'h01, 8'h03);
        tick();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h0F + i));
        while (exp_q.size() > 0) begin
            tick();
            chk("basic_count", 32'(count), 32'(exp_q.pop_front()));
        end
        chk("basic_done", 32'(done), 32'h1);
        tick();
        chk("basic_done_end", 32'(done), 32'h0);
        chk("basic_busy_end", 32'(busy), 32'h0);
        chk("basic_wrap", 32'(wrap), 32'h0);

        // Wrap
        send(8'hFE, 8'h03, 8'h01);
        tick(); tick();
        chk("wrap_load", 32'(count), 32'hFE);
        tick();
        chk("wrap_count", 32'(count), 32'h01);
        chk("wrap_flag", 32'(wrap), 32'h1);
        chk("wrap_done", 32'(done), 32'h1);

        // Zero length; wrap stays set until the LOAD edge
        send(8'h55, 8'h07, 8'h00);
        tick();
        chk("wrap_sticky", 32'(wrap), 32'h1);
        tick();
        chk("zero_count", 32'(count), 32'h55);
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_wrap", 32'(wrap), 32'h0);
        tick();
        chk("zero_done_end", 32'(done), 32'h0);

        // Hold for 4 cycles mid-run
        wait_idle();
        send(8'h00, 8'h02, 8'h05);
        tick(); tick(); tick();
        chk("hold_pre", 32'(count), 32'h02);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_frozen", 32'(count), 32'h02);
        end
        hold = 1'b0;
        for (int i = 2; i <= 5; i++) exp_q.push_back(8'(2 * i));
        while (exp_q.size() > 0) begin
            tick();
            chk("hold_count", 32'(count), 32'(exp_q.pop_front()));
        end
        chk("hold_done", 32'(done), 32'h1);
        chk("hold_final", 32'(count), 32'h0A);

        // Backpressure: 3 commands behind an active run
        wait_idle();
        done_log.delete();
        send(8'h00, 8'h01, 8'h06);
        send(8'h10, 8'h01, 8'h02);
        send(8'h20, 8'h02, 8'h02);
        chk("bp_ready", 32'(bus.cmd_ready), 32'h0);
        send(8'h30, 8'h03, 8'h01);
        wait_idle();
        exp_q.push_back(8'h06); exp_q.push_back(8'h12);
        exp_q.push_back(8'h24); exp_q.push_back(8'h33);
        chk("bp_runs", 32'(done_log.size()), 32'd4);
        while (exp_q.size() > 0 && done_log.size() > 0)
            chk("bp_order", 32'(done_log.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();

        // Abort mid-run with one queued
        send(8'h00, 8'h01, 8'h14);
        send(8'h80, 8'h01, 8'h02);
        tick(); tick(); tick();
        chk("abort_pre", 32'(count), 32'h02);
        abort = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_count", 32'(count), 32'h02);
        repeat (3) tick();
        chk("abort_flushed", 32'(busy), 32'h0);

        // Reset mid-run
        send(8'h40, 8'h01, 8'h14);
        repeat (4) tick();
        rstn = 1'b0;
        tick();
        chk("rst_mid_count", 32'(count), 32'h0);
        chk("rst_mid_busy",  32'(busy),  32'h0);
        chk("rst_mid_done",  32'(done),  32'h0);
        chk("rst_mid_ready", 32'(bus.cmd_ready), 32'h1);
        rstn = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_start = 8'($urandom_range(0, 255));
            bus.cmd_step  = 8'($urandom_range(0, 255));
            bus.cmd_len   = 8'($urandom_range(0, 5));
            hold  = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 49) == 0);
            tick();
        end
        bus.cmd_valid = 1'b0; hold = 1'b0; abort = 1'b0;
        wait_idle();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
